alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Sequential driver for the combinational ALU: accepts 32-bit MIPS instruction words over a valid/ready stream, buffers them, and owns the two-entry operand register file (regA, regB). It issues one instruction at a time to the ALU's instruction/regA/regB inputs and captures result/flags. It writes the result back to regA/regB and presents result plus flags on an output valid/ready stream.

## Interface
- FIFO_DEPTH, 4, instruction buffer entries (power of two, ≥2)
- INIT_A, 32'h0, reset value of regA
- INIT_B, 32'h0, reset value of regB

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  buffer can accept
- in_instr  in  32  instruction word
- ld_en  in  1  preload regA/regB (honoured only when busy=0)
- ld_sel  in  1  0 = regA, 1 = regB
- ld_data  in  32  preload value
- alu_instruction  out  32  to ALU instruction
- alu_regA  out  32  to ALU regA
- alu_regB  out  32  to ALU regB
- alu_result  in  32  from ALU result
- alu_flags  in  3  from ALU flags {zero, negative, overflow}
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_result  out  32  captured result
- out_flags  out  3  captured flags
- busy  out  1  state≠IDLE or buffer non-empty

## Operation
- **Register mapping.**
  - Register number 0 selects regA; any other number selects regB. This matches the ALU's operand selection.
  - Destination is rd (bits 15:11) when opcode (31:26) = 0, otherwise rt (20:16).
- **FSM states:** IDLE, EXEC, OUT.
  - IDLE: if buffer non-empty, pop the head into instr_q and go to EXEC.
  - EXEC: alu_instruction=instr_q. At the edge, latch out_result←alu_result and out_flags←alu_flags, write alu_result to the destination register, and go to OUT.
  - OUT: out_valid=1. Hold out_result and out_flags stable until out_valid&&out_ready. On that edge:
    - buffer non-empty: pop the head into instr_q and go to EXEC;
    - otherwise: go to IDLE.
- alu_regA/alu_regB are always driven from the regA/regB registers. alu_instruction holds instr_q in every state.
- **Buffer.** in_ready = (count < FIFO_DEPTH), from the registered count. A push and a pop on the same edge leave count unchanged. A push into a full buffer is impossible because in_ready=0.
- **Preload.** ld_en when busy=0 writes ld_data to the selected register at the edge. ld_en when busy=1 is ignored with no side effect. A preload and a push on the same edge are both honoured, and the popped instruction sees the preloaded value.
- Every instruction is written back regardless of funct/opcode support. Writeback happens exactly once per instruction, in EXEC.
- **Reset (asserted at any time, including mid-instruction):**
  - buffer emptied, state=IDLE, instr_q=0;
  - out_valid=0, out_result=0, out_flags=0, busy=0;
  - in_ready=1 while reset is deasserted;
  - regA=INIT_A, regB=INIT_B;
  - pending results are discarded.

## Timing
- Accept edge E0 with the unit idle and the buffer empty:
  - pop at E1;
  - capture and writeback at E2;
  - out_valid high from after E2.
- Accept-to-out_valid latency is 2 cycles.
- With out_ready held high, throughput is one result per 2 cycles (OUT→EXEC→OUT).
- A dependent instruction issued next reads the written-back value, because writeback completes before its EXEC.
- out_ready low stalls in OUT indefinitely. The buffer keeps accepting until full.

## Structure
- **Package alu_issue_pkg:**
  - state enum {IDLE, EXEC, OUT};
  - OP_RTYPE=6'h00, FUNCT_ADDU=6'h21, OP_ADDIU=6'h09;
  - instruction field bit positions;
  - flag bit indices ZF=2, NF=1, VF=0.
- **Sub-module alu_issue_fifo:** synchronous FIFO with count, parameterised by FIFO_DEPTH and width 32, with the same clk/rst_n.
- The ALU itself is instantiated outside this block.

## Test plan
- **Preload and addu.** Preload regA=5, regB=7. Push 0x00010821 (addu rd=1, rs=0, rt=1) → out_result=12, out_flags=3'b000, regB=12, with out_valid 2 cycles after the accept edge.
- **Sign-extended addiu.** regA=5. Push 0x2400FFFF (addiu rt=0, rs=0, imm=−1) → out_result=4, regA=4.
- **Back-to-back dependency.** Push 0x00010821 then 0x24210001 with out_ready=1 → results 12 then 13, with regB=13 at the end.
- **Backpressure.** out_ready=0 and push 6 words.
  - The first word pops to EXEC; 4 more fill the buffer; in_ready drops after the 5th accept.
  - out_result stays stable.
  - Raising out_ready drains all 5 results in order.
- **Reset mid-operation.** Assert rst_n=0 while in OUT with 2 words buffered → immediately out_valid=0, busy=0, regA/regB=INIT values. After release there is no output until a new push.
- **Preload ignored when busy.** ld_en=1 with busy=1 → target register unchanged. ld_en with busy=0 on the same edge as a push → the instruction uses the loaded value.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared definitions for the ALU issue unit: FSM state type, MIPS opcode /
//   funct constants, instruction field positions, flag bit indices and the
//   destination-register selection helper.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] OP_ADDIU   = 6'h09;

  localparam int unsigned OPCODE_HI = 31;
  localparam int unsigned OPCODE_LO = 26;
  localparam int unsigned RS_HI     = 25;
  localparam int unsigned RS_LO     = 21;
  localparam int unsigned RT_HI     = 20;
  localparam int unsigned RT_LO     = 16;
  localparam int unsigned RD_HI     = 15;
  localparam int unsigned RD_LO     = 11;
  localparam int unsigned FUNCT_HI  = 5;
  localparam int unsigned FUNCT_LO  = 0;
  localparam int unsigned IMM_HI    = 15;
  localparam int unsigned IMM_LO    = 0;

  localparam int unsigned ZF = 2;
  localparam int unsigned NF = 1;
  localparam int unsigned VF = 0;

  // Destination is rd for R-type, rt otherwise; register 0 maps to regA,
  // any other number maps to regB. Returns 1 when regB is the target.
  function automatic logic dest_is_b(input logic [31:0] instr);
    logic [4:0] dst;
    if (instr[OPCODE_HI:OPCODE_LO] == OP_RTYPE) dst = instr[RD_HI:RD_LO];
    else                                        dst = instr[RT_HI:RT_LO];
    return (dst != 5'd0);
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo
//   Synchronous FIFO with occupancy count, used as the instruction buffer.
//   Ports:
//     clk, rst_n    rising-edge clock, asynchronous active-low reset
//     push, wr_data write side (ignored when full)
//     pop, rd_data  read side; rd_data is the current head (ignored when empty)
//     empty, full   status derived from the registered count
module alu_issue_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != DEPTH_CNT);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // Depth is a power of two, so pointers wrap naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Sequential driver for an external combinational MIPS ALU. Buffers
//   instruction words, issues them one at a time, writes each result back to
//   the two-entry operand file (regA/regB) and presents result + flags on an
//   output valid/ready stream.
//   Ports:
//     in_valid/in_ready/in_instr      instruction input stream
//     ld_en/ld_sel/ld_data            operand preload (only while not busy)
//     alu_instruction/alu_regA/B      to the ALU
//     alu_result/alu_flags            from the ALU ({zero, negative, overflow})
//     out_valid/out_ready/out_result/out_flags   result output stream
//     busy                            FSM not idle or buffer non-empty
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] INIT_A     = 32'h0,
  parameter logic [31:0] INIT_B     = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        ld_en,
  input  logic        ld_sel,
  input  logic [31:0] ld_data,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_regA,
  output logic [31:0] alu_regB,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] reg_a_q, reg_a_d;
  logic [31:0] reg_b_q, reg_b_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic [2:0]  out_flags_q, out_flags_d;

  logic        fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [31:0] fifo_head;

  alu_issue_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (32)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (fifo_push),
    .wr_data(in_instr),
    .pop    (fifo_pop),
    .rd_data(fifo_head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign busy      = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    reg_a_d      = reg_a_q;
    reg_b_d      = reg_b_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    fifo_pop     = 1'b0;

    // Preload and EXEC writeback never collide: busy is high throughout EXEC.
    if (ld_en && !busy) begin
      if (ld_sel) reg_b_d = ld_data;
      else        reg_a_d = ld_data;
    end

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          instr_d  = fifo_head;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        out_result_d = alu_result;
        out_flags_d  = alu_flags;
        out_valid_d  = 1'b1;
        if (dest_is_b(instr_q)) reg_b_d = alu_result;
        else                    reg_a_d = alu_result;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            instr_d  = fifo_head;
            state_d  = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      reg_a_q      <= INIT_A;
      reg_b_q      <= INIT_B;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      reg_a_q      <= reg_a_d;
      reg_b_q      <= reg_b_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign alu_instruction = instr_q;
  assign alu_regA        = reg_a_q;
  assign alu_regB        = reg_b_q;
  assign out_valid       = out_valid_q;
  assign out_result      = out_result_q;
  assign out_flags       = out_flags_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit
//   Bench for alu_issue_unit. Provides a behavioural ALU on the alu_* ports
//   and keeps a transaction-level model: the list of accepted instructions,
//   the two operand values, and the rule that each result is produced in
//   acceptance order using the operand values left by its predecessors.
module tb_alu_issue_unit;
  import alu_issue_pkg::*;

  localparam logic [31:0] P_INIT_A = 32'h1111_0000;
  localparam logic [31:0] P_INIT_B = 32'h0000_2222;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic        ld_en, ld_sel;
  logic [31:0] ld_data;
  logic [31:0] alu_instruction, alu_regA, alu_regB, alu_result;
  logic [2:0]  alu_flags;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic        busy;

  alu_issue_unit #(
    .FIFO_DEPTH(4),
    .INIT_A    (P_INIT_A),
    .INIT_B    (P_INIT_B)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .ld_en          (ld_en),
    .ld_sel         (ld_sel),
    .ld_data        (ld_data),
    .alu_instruction(alu_instruction),
    .alu_regA       (alu_regA),
    .alu_regB       (alu_regB),
    .alu_result     (alu_result),
    .alu_flags      (alu_flags),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_flags      (out_flags),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural ALU: returns {zero, negative, overflow, result}.
  function automatic logic [34:0] alu_ref(input logic [31:0] ins,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] s, t, r, imm;
    logic        ov;
    s   = (ins[25:21] == 5'd0) ? a : b;
    t   = (ins[20:16] == 5'd0) ? a : b;
    imm = {{16{ins[15]}}, ins[15:0]};
    r   = '0;
    ov  = 1'b0;
    if (ins[31:26] == OP_RTYPE && ins[5:0] == FUNCT_ADDU) begin
      r  = s + t;
      ov = (s[31] == t[31]) && (r[31] != s[31]);
    end else if (ins[31:26] == OP_ADDIU) begin
      r  = s + imm;
      ov = (s[31] == imm[31]) && (r[31] != s[31]);
    end
    return {(r == 32'd0), r[31], ov, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_ref(alu_instruction, alu_regA, alu_regB);

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] exp_q[$];     // accepted, not yet delivered
  logic [31:0] got_res[$];   // delivered results, in order
  int unsigned hs_cyc[$];    // cycle numbers of output handshakes
  logic [31:0] m_a, m_b;
  int unsigned cyc = 0;

  // Observe one clock edge: decide from pre-edge signals what the edge does,
  // update the model, then advance to just after the edge.
  task automatic tick();
    logic        acc, hs, ld_ok;
    logic [31:0] ins;
    logic [34:0] res;
    logic [4:0]  dst;
    acc   = in_valid && in_ready;
    hs    = out_valid && out_ready;
    ld_ok = ld_en && (exp_q.size() == 0);
    if (hs) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        ins = exp_q.pop_front();
        res = alu_ref(ins, m_a, m_b);
        dst = (ins[31:26] == 6'd0) ? ins[15:11] : ins[20:16];
        if (dst == 5'd0) m_a = res[31:0];
        else             m_b = res[31:0];
        check("result", out_result, res[31:0]);
        check("flags", {29'd0, out_flags}, {29'd0, res[34:32]});
        check("wb_regA", alu_regA, m_a);
        check("wb_regB", alu_regB, m_b);
        got_res.push_back(out_result);
        hs_cyc.push_back(cyc);
      end
    end
    if (ld_ok) begin
      if (ld_sel) m_b = ld_data;
      else        m_a = ld_data;
    end
    if (acc) exp_q.push_back(in_instr);
    @(posedge clk);
    #1;
    cyc++;
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
  endtask

  task automatic push_word(input logic [31:0] w);
    int unsigned n;
    n        = 0;
    in_valid = 1'b1;
    in_instr = w;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    else           tick();
    in_valid = 1'b0;
  endtask

  task automatic preload(input logic sel, input logic [31:0] v);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_data = v;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n         = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    ld_en     = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [4:0]  rs, rt, rd;
    rs = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    rt = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    rd = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    case ($urandom_range(0, 3))
      0, 1:    w = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADDU};
      2:       w = {OP_ADDIU, rs, rt, 16'($urandom)};
      default: w = $urandom;
    endcase
    return w;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    ld_en     = 1'b0;
    ld_sel    = 1'b0;
    ld_data   = '0;
    out_ready = 1'b0;
    m_a       = P_INIT_A;
    m_b       = P_INIT_B;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_regA", alu_regA, P_INIT_A);
    check("rst_regB", alu_regB, P_INIT_B);
    check("rst_result", out_result, 32'd0);
    check("rst_flags", {29'd0, out_flags}, 32'd0);
    check("rst_instr", alu_instruction, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Preload and addu, with accept-to-valid latency
    preload(1'b0, 32'd5);
    preload(1'b1, 32'd7);
    check("pre_regA", alu_regA, 32'd5);
    check("pre_regB", alu_regB, 32'd7);
    push_word(32'h0001_0821);
    check("lat_e0", 32'(out_valid), 32'd0);
    tick();
    check("lat_e1", 32'(out_valid), 32'd0);
    tick();
    check("lat_e2", 32'(out_valid), 32'd1);
    check("addu_result", out_result, 32'd12);
    check("addu_flags", {29'd0, out_flags}, 32'd0);
    check("addu_regB", alu_regB, 32'd12);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Sign-extended addiu
    push_word(32'h2400_FFFF);
    drain();
    check("addiu_result", got_res[got_res.size()-1], 32'd4);
    check("addiu_regA", alu_regA, 32'd4);

    // Back-to-back dependency and throughput
    preload(1'b0, 32'd5);
    preload(1'b1, 32'd7);
    got_res.delete();
    hs_cyc.delete();
    out_ready = 1'b1;
    push_word(32'h0001_0821);
    push_word(32'h2421_0001);
    drain();
    check("b2b_count", 32'(got_res.size()), 32'd2);
    if (got_res.size() == 2) begin
      check("b2b_first", got_res[0], 32'd12);
      check("b2b_second", got_res[1], 32'd13);
      check("b2b_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
    end
    check("b2b_regB", alu_regB, 32'd13);

    // Backpressure: stall in OUT, fill the buffer, then drain
    preload(1'b0, 32'd100);
    got_res.delete();
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) push_word(32'h2400_0001);
    check("bp_full", 32'(in_ready), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_held", out_result, 32'd101);
    in_valid = 1'b1;
    in_instr = 32'h2400_0001;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("bp_stall_hold", out_result, 32'd101);
      check("bp_stall_full", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    push_word(32'h2400_0001);
    drain();
    check("bp_count", 32'(got_res.size()), 32'd6);
    for (int unsigned i = 0; i < got_res.size(); i++)
      check("bp_order", got_res[i], 32'd101 + 32'(i));
    check("bp_regA", alu_regA, 32'd106);

    // Reset while in OUT with two words buffered
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) push_word(32'h0001_0821);
    check("mid_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_regA", alu_regA, P_INIT_A);
    check("mid_rst_regB", alu_regB, P_INIT_B);
    exp_q.delete();
    m_a = P_INIT_A;
    m_b = P_INIT_B;
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    // Preload ignored while busy; honoured together with a push when idle
    out_ready = 1'b0;
    push_word(32'h0001_0821);
    tick();
    tick();
    preload(1'b0, 32'h0000_DEAD);
    check("busy_ld_ignored", alu_regA, P_INIT_A);
    drain();
    check("busy_ld_regB", alu_regB, P_INIT_A + P_INIT_B);
    ld_en   = 1'b1;
    ld_sel  = 1'b1;
    ld_data = 32'h40;
    push_word(32'h0001_0821);
    ld_en = 1'b0;
    drain();
    check("same_edge_ld", got_res[got_res.size()-1], P_INIT_A + 32'h40);

    // Randomised traffic against the model
    for (int unsigned i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_instr  = rand_instr();
      ld_en     = ($urandom_range(0, 3) == 0);
      ld_sel    = 1'($urandom_range(0, 1));
      ld_data   = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();
    check("final_regA", alu_regA, m_a);
    check("final_regB", alu_regB, m_b);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
